// File: rtl/systolic_pkg.sv
// Shared definitions for the NxN output-stationary systolic matrix multiplier.
package systolic_pkg;

  localparam int unsigned DefN  = 3;
  localparam int unsigned DefDW = 8;
  localparam int unsigned DefKW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StDrain
  } state_e;

endpackage

// File: rtl/pe_acc.sv
// Processing element: registers operands through to its neighbours and accumulates
// the unsigned product of its current inputs.
module pe_acc #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic [AW-1:0] o_acc
);

  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [AW-1:0]   r_acc;
  logic [2*DW-1:0] w_prod;

  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= r_acc + AW'(w_prod);
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_nxn.sv
// NxN systolic matrix multiplier: streams K columns of A / rows of B through skewed
// lines into a PE grid, then drains C in raster order over a valid/ready port.
module systolic_array_nxn
  import systolic_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDW,
  parameter int unsigned KW = DefKW,
  parameter int unsigned AW = 2 * DW + KW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      a_vec,
  input  logic [N*DW-1:0]      b_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_row,
  output logic [$clog2(N)-1:0] out_col,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned FW = $clog2(2 * N);
  localparam logic [FW-1:0] FlushLast = FW'(2 * N - 2);
  localparam logic [IW-1:0] IdxLast   = IW'(N - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [KW-1:0]   r_cnt;
  logic [FW-1:0]   r_flush;
  logic [IW-1:0]   r_row;
  logic [IW-1:0]   r_col;
  logic            w_start;
  logic            w_accept;
  logic            w_last;

  logic [DW-1:0]   w_a_h [N][N+1];
  logic [DW-1:0]   w_b_v [N+1][N];
  logic [AW-1:0]   w_acc [N][N];

  assign w_start  = (r_state == StIdle) && start;
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_row == IdxLast) && (r_col == IdxLast);
  assign busy     = (r_state != StIdle);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) w_state_nxt = (k_len == '0) ? StDrain : StLoad;
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid && (r_cnt == KW'(1))) w_state_nxt = StFlush;
      end
      StFlush: begin
        if (r_flush == '0) w_state_nxt = StDrain;
      end
      StDrain: begin
        out_valid = 1'b1;
        if (out_ready && w_last) begin
          done        = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_flush <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt <= k_len;
      end else if (w_accept) begin
        r_cnt <= r_cnt - KW'(1);
      end
      // Flush counter runs 2N-2 down to 0, giving 2N-1 cycles of zero injection.
      if ((r_state == StLoad) && (w_state_nxt == StFlush)) begin
        r_flush <= FlushLast;
      end else if ((r_state == StFlush) && (r_flush != '0)) begin
        r_flush <= r_flush - FW'(1);
      end
      if (out_valid && out_ready) begin
        if (r_col == IdxLast) begin
          r_col <= '0;
          r_row <= w_last ? '0 : r_row + IW'(1);
        end else begin
          r_col <= r_col + IW'(1);
        end
      end
    end
  end

  // Skew lines: row i of A and column i of B are delayed i cycles; idle cycles inject zeros.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DW-1:0] w_a_src;
    logic [DW-1:0] w_b_src;

    assign w_a_src = w_accept ? a_vec[gi*DW +: DW] : '0;
    assign w_b_src = w_accept ? b_vec[gi*DW +: DW] : '0;

    if (gi == 0) begin : g_direct
      assign w_a_h[gi][0] = w_a_src;
      assign w_b_v[0][gi] = w_b_src;
    end else begin : g_delay
      logic [DW-1:0] r_a_sk [gi];
      logic [DW-1:0] r_b_sk [gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < gi; d++) begin
            r_a_sk[d] <= '0;
            r_b_sk[d] <= '0;
          end
        end else begin
          r_a_sk[0] <= w_a_src;
          r_b_sk[0] <= w_b_src;
          for (int d = 1; d < gi; d++) begin
            r_a_sk[d] <= r_a_sk[d-1];
            r_b_sk[d] <= r_b_sk[d-1];
          end
        end
      end

      assign w_a_h[gi][0] = r_a_sk[gi-1];
      assign w_b_v[0][gi] = r_b_sk[gi-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      pe_acc #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_start),
        .i_a   (w_a_h[gi][gj]),
        .i_b   (w_b_v[gi][gj]),
        .o_a   (w_a_h[gi][gj+1]),
        .o_b   (w_b_v[gi+1][gj]),
        .o_acc (w_acc[gi][gj])
      );
    end
  end

  // Accumulators see only zeros during DRAIN, so the selected element stays stable.
  assign out_data = out_valid ? w_acc[r_row][r_col] : '0;
  assign out_row  = r_row;
  assign out_col  = r_col;

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Randomized self-checking bench for systolic_array_nxn against a plain matrix-product model.
module tb_systolic_array_nxn;

  localparam int unsigned N    = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned KW   = 8;
  localparam int unsigned AW   = 2 * DW + KW;
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned MaxK = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_vec;
  logic [N*DW-1:0] b_vec;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_data;
  logic [IW-1:0]   out_row;
  logic [IW-1:0]   out_col;
  logic            busy;
  logic            done;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] mat_a [N][MaxK];
  logic [DW-1:0] mat_b [MaxK][N];
  logic [AW-1:0] c_exp [N][N];

  always #5 clk = ~clk;

  systolic_array_nxn #(
    .N (N),
    .DW(DW),
    .KW(KW),
    .AW(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_col  (out_col),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: A identity, B = 1..9 raster; mode 1: all operands 255; mode 2: random.
  task automatic fill(input int mode, input int k);
    for (int i = 0; i < N; i++) begin
      for (int kk = 0; kk < k; kk++) begin
        case (mode)
          0:       mat_a[i][kk] = (i == kk) ? DW'(1) : DW'(0);
          1:       mat_a[i][kk] = DW'(255);
          default: mat_a[i][kk] = DW'($urandom);
        endcase
      end
    end
    for (int kk = 0; kk < k; kk++) begin
      for (int j = 0; j < N; j++) begin
        case (mode)
          0:       mat_b[kk][j] = DW'(N * kk + j + 1);
          1:       mat_b[kk][j] = DW'(255);
          default: mat_b[kk][j] = DW'($urandom);
        endcase
      end
    end
  endtask

  task automatic model(input int k);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [AW-1:0] s;
        s = '0;
        for (int kk = 0; kk < k; kk++) s += AW'(mat_a[i][kk]) * AW'(mat_b[kk][j]);
        c_exp[i][j] = s;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the final handshake.
  // stall: 0 none, 1 toggle, 2 random.
  task automatic run_op(input string name, input int k, input bit gaps, input int stall,
                        input bit poke_start);
    int            beat;
    int            cyc;
    int            idx;
    int            dones;
    bit            stalled;
    bit            rdy;
    logic [AW-1:0] h_data;
    logic [IW-1:0] h_row;
    logic [IW-1:0] h_col;

    model(k);
    start = 1'b1;
    k_len = KW'(k);
    dones = 0;
    @(negedge clk);
    start = 1'b0;
    k_len = KW'($urandom);
    cyc   = 1;
    check_eq({name, "_busy"}, 64'(busy), 64'd1);
    beat = 0;
    while (beat < k && cyc < 400) begin
      in_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      for (int i = 0; i < N; i++) begin
        a_vec[i*DW +: DW] = in_valid ? mat_a[i][beat] : DW'($urandom);
        b_vec[i*DW +: DW] = in_valid ? mat_b[beat][i] : DW'($urandom);
      end
      rdy = in_ready;
      @(negedge clk);
      cyc++;
      if (in_valid && rdy) beat++;
    end
    in_valid = 1'b0;
    a_vec    = N*DW'($urandom);
    b_vec    = N*DW'($urandom);
    if (k > 0) check_eq({name, "_flush_rdy"}, 64'(in_ready), 64'd0);
    while (!out_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      check_eq({name, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (k > 0 && !gaps) check_eq({name, "_latency"}, 64'(cyc), 64'(k + 2 * N));

    idx     = 0;
    stalled = 1'b0;
    while (idx < N * N && cyc < 800) begin
      check_eq($sformatf("%s_valid%0d", name, idx), 64'(out_valid), 64'd1);
      if (stalled) begin
        check_eq($sformatf("%s_hold_data%0d", name, idx), 64'(out_data), 64'(h_data));
        check_eq($sformatf("%s_hold_pos%0d", name, idx), 64'({out_row, out_col}),
                 64'({h_row, h_col}));
      end
      case (stall)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2) == 1;
        default: out_ready = 1'($urandom);
      endcase
      if (poke_start && idx == 1) begin
        start = 1'b1;
        k_len = KW'($urandom_range(1, 5));
      end
      #1;
      if (done) dones++;
      if (out_ready) begin
        check_eq($sformatf("%s_c%0d", name, idx), 64'(out_data), 64'(c_exp[idx/N][idx%N]));
        check_eq($sformatf("%s_row%0d", name, idx), 64'(out_row), 64'(idx / N));
        check_eq($sformatf("%s_col%0d", name, idx), 64'(out_col), 64'(idx % N));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        h_data  = out_data;
        h_row   = out_row;
        h_col   = out_col;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    check_eq({name, "_drained"}, 64'(idx), 64'(N * N));
    check_eq({name, "_done_cnt"}, 64'(dones), 64'd1);
    check_eq({name, "_idle_busy"}, 64'(busy), 64'd0);
    check_eq({name, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_in_ready"}, 64'(in_ready), 64'd0);
    check_eq({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({name, "_busy"}, 64'(busy), 64'd0);
    check_eq({name, "_done"}, 64'(done), 64'd0);
    check_eq({name, "_out_data"}, 64'(out_data), 64'd0);
    check_eq({name, "_out_pos"}, 64'({out_row, out_col}), 64'd0);
  endtask

  initial begin
    int seen;
    reset     = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_vec     = '0;
    b_vec     = '0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    fill(0, 3);
    run_op("ident", 3, 1'b0, 0, 1'b0);
    fill(1, 1);
    run_op("ff_k1", 1, 1'b0, 0, 1'b0);
    fill(1, 3);
    run_op("ff_k3", 3, 1'b0, 0, 1'b0);
    fill(0, 3);
    run_op("gaps", 3, 1'b1, 0, 1'b0);
    run_op("stall", 3, 1'b0, 1, 1'b0);
    run_op("k0", 0, 1'b0, 0, 1'b1);

    // Abandon an operation mid-LOAD with an asynchronous reset pulse.
    fill(2, 4);
    start = 1'b1;
    k_len = KW'(4);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    a_vec    = N*DW'($urandom);
    b_vec    = N*DW'($urandom);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    seen     = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check_eq("mid_rst_quiet", 64'(seen), 64'd0);
    fill(0, 3);
    run_op("ident_post_rst", 3, 1'b0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(1, MaxK);
      fill(2, k);
      run_op($sformatf("rand%0d", r), k, 1'($urandom), 2, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
